// File: rtl/countdown_seq_ctrl.sv
// Sequencer for a cascade of 4-bit down-counting digits forming a countdown timer.
// Optional periodic mode: define AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_seq_ctrl #(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 100000000,
  parameter int BCD_MODE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  input  logic [4*NUM_DIGITS-1:0] preset,
  input  logic [NUM_DIGITS-1:0]   digit_done,
  output logic                    cnt_load,
  output logic [4*NUM_DIGITS-1:0] cnt_load_val,
  output logic [NUM_DIGITS-1:0]   cnt_enable,
  output logic                    cnt_updown,
  output logic                    cnt_mode,
  output logic                    running,
  output logic                    expired
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [PW-1:0]   prescaler;
  logic            tick;
  logic            all_done;
  logic            expire;
  logic            reload;
  logic            chain;

  assign tick     = (state == RUN) && (prescaler == TICK_LAST);
  assign all_done = &digit_done;
  assign expire   = tick && all_done;

`ifdef AUTO_RELOAD_EN
  assign reload = expire;
`else
  assign reload = 1'b0;
`endif

  assign cnt_updown = 1'b0;
  assign cnt_mode   = (BCD_MODE != 0);

  // clear beats start beats pause; start is deliberately absent from RUN
  always_comb begin
    nxt = state;
    if (clear && state != CLR) begin
      nxt = CLR;
    end else begin
      case (state)
        IDLE, EXPIRED: if (start) nxt = LOAD;
        LOAD:          nxt = RUN;
        CLR:           nxt = IDLE;
        RUN: begin
          if (expire)     nxt = reload ? LOAD : EXPIRED;
          else if (pause) nxt = PAUSE;
        end
        PAUSE: begin
          if (start)      nxt = LOAD;
          else if (pause) nxt = RUN;
        end
        default:       nxt = IDLE;
      endcase
    end
  end

  // A digit borrows only when every lower digit is already at zero
  always_comb begin
    cnt_enable = '0;
    chain      = tick & ~all_done;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cnt_enable[i] = chain;
      chain         = chain & digit_done[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      prescaler    <= '0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      running      <= 1'b0;
      expired      <= 1'b0;
    end else begin
      state        <= nxt;
      cnt_load     <= (nxt == LOAD) || (nxt == CLR);
      cnt_load_val <= (nxt == LOAD) ? preset : '0;
      running      <= (nxt == RUN) || ((nxt == LOAD) && reload);
      expired      <= (nxt == EXPIRED) || ((nxt == LOAD) && reload);
      if (state == LOAD) begin
        prescaler <= '0;
      end else if (state == RUN) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
      end
    end
  end

endmodule
